mlacc_trace_packer: RTL and testbench

- Sits directly downstream of mlacc_top and consumes its ila_trig / monitored_signal outputs.
- On each trigger cycle it captures six 32-bit counter fields plus a cycle timestamp as one record, and buffers records in an on-chip FIFO.
- It drains each record as 7 beats on a 32-bit valid/ready stream, which feeds the detection logic or a host readout path.
- It counts records lost to FIFO overflow.

---
 rtl/mlacc_trace_pkg.sv | 23 ++
 rtl/mlacc_trace_packer_if.sv | 28 ++
 rtl/mlacc_trace_fifo.sv | 55 +++++
 rtl/mlacc_trace_packer.sv | 169 ++++++++++++++++
 tb/tb_mlacc_trace_packer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlacc_trace_pkg.sv
// Shared definitions for the trace packer.
//   - Field slice offsets into the 256-bit monitored_signal snapshot, in the
//     order the fields leave the stream after the timestamp word.
//   - Number of stream words per record and the index of the final beat.
//   - Serializer state encoding.
package mlacc_trace_pkg;

  localparam int MON_F0_LSB    = 0;
  localparam int MON_F1_LSB    = 64;
  localparam int MON_F2_LSB    = 224;
  localparam int MON_F3_LSB    = 192;
  localparam int MON_F4_LSB    = 160;
  localparam int MON_F5_LSB    = 128;

  localparam int WORDS_PER_REC = 7;
  localparam logic [2:0] LAST_BEAT = 3'(WORDS_PER_REC - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/mlacc_trace_packer_if.sv
// Valid/ready output stream of the trace packer.
//   out_data  : one 32-bit record word
//   out_valid : word is valid
//   out_ready : consumer accepts the word
//   out_last  : final word (beat 6) of a record
// master = packer side, slave = consumer side.
interface mlacc_trace_packer_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/mlacc_trace_fifo.sv
// Synchronous record FIFO, 2^DEPTH_LOG2 entries of WIDTH bits.
//   i_clk, i_rst_n  : clock, synchronous active-low reset (pointers only)
//   i_push, i_wdata : write one entry (caller guarantees not full)
//   i_pop           : drop the head entry (caller guarantees not empty)
//   o_rdata         : head entry (combinational read of registered pointer)
//   o_rdata_next    : entry behind the head, used for gapless record switch
//   o_level         : stored entries, derived from pointers with wrap bit
//   o_full, o_empty : level == depth / level == 0
module mlacc_trace_fifo #(
  parameter int WIDTH      = 224,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_rdata,
  output logic [WIDTH-1:0]      o_rdata_next,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_rd_ptr;
  logic [DEPTH_LOG2-1:0] w_rd_idx_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only entries between the pointers are meaningful.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wdata;
  end

  assign w_rd_idx_next = r_rd_ptr[DEPTH_LOG2-1:0] + 1'b1;
  assign o_rdata       = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign o_rdata_next  = r_mem[w_rd_idx_next];
  assign o_level       = r_wr_ptr - r_rd_ptr;
  assign o_full        = (o_level == LVL_FULL);
  assign o_empty       = (o_level == '0);

endmodule

// File: rtl/mlacc_trace_packer.sv
// Trace packer: captures a timestamp plus six 32-bit fields of
// monitored_signal on every ila_trig, queues the records and serializes each
// as 7 words on a valid/ready stream. Records that arrive while the queue is
// full are counted in a saturating drop counter and flag a sticky overflow.
//   in_clk, in_reset : clock, synchronous active-low reset
//   ila_trig         : capture strobe
//   monitored_signal : 256-bit snapshot bus
//   strm             : output stream (out_data/out_valid/out_ready/out_last)
//   fifo_level       : records held, including the one being sent
//   drop_count       : records discarded while full (saturating)
//   overflow         : sticky, set on the first drop
module mlacc_trace_packer
  import mlacc_trace_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  ila_trig,
  input  logic [255:0]          monitored_signal,
  mlacc_trace_packer_if.master  strm,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [CNT_W-1:0]      drop_count,
  output logic                  overflow
);

  localparam int REC_W = WORDS_PER_REC * DATA_W;
  localparam logic [DEPTH_LOG2:0] LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] rec_word(input logic [REC_W-1:0] rec,
                                                 input logic [2:0]       idx);
    return rec[int'(idx)*DATA_W +: DATA_W];
  endfunction

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_beat, w_beat_nxt, w_beat_inc;
  logic                r_valid, w_valid_nxt;
  logic                r_last, w_last_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [DATA_W-1:0]   r_ts;
  logic [CNT_W-1:0]    r_drop;
  logic                r_ovf;

  logic [REC_W-1:0]    w_rec, w_head, w_head_next, w_next_rec;
  logic [DEPTH_LOG2:0] w_level;
  logic                w_full, w_empty;
  logic                w_push, w_drop, w_hs, w_pop, w_more_after_pop;
  logic                w_unused_mon;

  // Word 0 sits at the LSB so beat n is rec[n*DATA_W +: DATA_W].
  assign w_rec = {monitored_signal[MON_F5_LSB +: DATA_W],
                  monitored_signal[MON_F4_LSB +: DATA_W],
                  monitored_signal[MON_F3_LSB +: DATA_W],
                  monitored_signal[MON_F2_LSB +: DATA_W],
                  monitored_signal[MON_F1_LSB +: DATA_W],
                  monitored_signal[MON_F0_LSB +: DATA_W],
                  r_ts};
  assign w_unused_mon = ^{monitored_signal[127:96], monitored_signal[63:32]};

  // Fullness uses the registered level, so a pop in the same cycle does not
  // make room for the incoming record.
  assign w_push = ila_trig & ~w_full;
  assign w_drop = ila_trig &  w_full;

  assign w_hs       = r_valid & strm.out_ready;
  assign w_pop      = (r_state == ST_SEND) & w_hs & (r_beat == LAST_BEAT);
  assign w_beat_inc = r_beat + 3'd1;

  // After the final beat the next head is either already stored behind the
  // current one, or is the record being captured in this very cycle.
  assign w_more_after_pop = (w_level > LVL_ONE) | w_push;
  assign w_next_rec       = (w_level > LVL_ONE) ? w_head_next : w_rec;

  mlacc_trace_fifo #(
    .WIDTH      (REC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_clk        (in_clk),
    .i_rst_n      (in_reset),
    .i_push       (w_push),
    .i_wdata      (w_rec),
    .i_pop        (w_pop),
    .o_rdata      (w_head),
    .o_rdata_next (w_head_next),
    .o_level      (w_level),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_data_nxt  = r_data;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_SEND;
          w_beat_nxt  = 3'd0;
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_data_nxt  = rec_word(w_head, 3'd0);
        end
      end
      ST_SEND: begin
        if (w_hs) begin
          if (r_beat == LAST_BEAT) begin
            w_beat_nxt = 3'd0;
            w_last_nxt = 1'b0;
            if (w_more_after_pop) begin
              w_data_nxt = rec_word(w_next_rec, 3'd0);
            end else begin
              w_state_nxt = ST_IDLE;
              w_valid_nxt = 1'b0;
              w_data_nxt  = '0;
            end
          end else begin
            w_beat_nxt = w_beat_inc;
            w_last_nxt = (w_beat_inc == LAST_BEAT);
            w_data_nxt = rec_word(w_head, w_beat_inc);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_reset) begin
      r_state <= ST_IDLE;
      r_beat  <= 3'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_ts    <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_data  <= w_data_nxt;
      r_ts    <= r_ts + 1'b1;
      if (w_drop) begin
        r_drop <= sat_inc(r_drop);
        r_ovf  <= 1'b1;
      end
    end
  end

  assign strm.out_data  = r_data;
  assign strm.out_valid = r_valid;
  assign strm.out_last  = r_last;
  assign fifo_level     = w_level;
  assign drop_count     = r_drop;
  assign overflow       = r_ovf;

endmodule

// File: tb/tb_mlacc_trace_packer.sv
module tb_mlacc_trace_packer;
  localparam int DATA_W = 32, DEPTH_LOG2 = 4, CNT_W = 16, DEPTH = 16;

  logic                 in_clk = 1'b0;
  logic                 in_reset = 1'b0;
  logic                 ila_trig = 1'b0;
  logic [255:0]         monitored_signal = '0;
  logic [DEPTH_LOG2:0]  fifo_level;
  logic [CNT_W-1:0]     drop_count;
  logic                 overflow;

  mlacc_trace_packer_if #(.DATA_W(DATA_W)) u_if ();

  mlacc_trace_packer #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .CNT_W(CNT_W)) dut (
    .in_clk           (in_clk),
    .in_reset         (in_reset),
    .ila_trig         (ila_trig),
    .monitored_signal (monitored_signal),
    .strm             (u_if),
    .fifo_level       (fifo_level),
    .drop_count       (drop_count),
    .overflow         (overflow)
  );

  always #5 in_clk = ~in_clk;

  int n_chk = 0, n_fail = 0, cyc = 0;

  typedef logic [6:0][31:0] rec_t;
  rec_t        mq[$];
  bit          m_send = 0;
  int          m_beat = 0;
  logic [31:0] m_ts = 0;
  int          m_drop = 0;
  bit          m_ovf = 0;

  logic [31:0] log_data[$];
  bit          log_last[$];
  int          log_cyc[$];
  logic        p_valid = 0, p_last = 0;
  logic [31:0] p_data = 0;

  int mo[7] = '{0, 0, 2, 7, 6, 5, 4};
  bit rpat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic rec_t mkrec(input logic [31:0] ts, input logic [255:0] m);
    rec_t r;
    r[0] = ts;          r[1] = m[31:0];     r[2] = m[95:64];  r[3] = m[255:224];
    r[4] = m[223:192];  r[5] = m[191:160];  r[6] = m[159:128];
    return r;
  endfunction

  function automatic int count_lasts();
    int c = 0;
    foreach (log_last[i]) if (log_last[i]) c++;
    return c;
  endfunction

  // Reference model and per-cycle comparison.
  always @(posedge in_clk) begin
    int old;
    bit popped;
    if (in_reset && p_valid && u_if.out_ready) begin
      log_data.push_back(p_data);
      log_last.push_back(p_last);
      log_cyc.push_back(cyc);
    end
    if (!in_reset) begin
      mq.delete();
      m_send = 0; m_beat = 0; m_ts = 0; m_drop = 0; m_ovf = 0;
    end else begin
      old = mq.size();
      popped = 0;
      if (m_send && u_if.out_ready) begin
        if (m_beat == 6) begin
          void'(mq.pop_front());
          m_beat = 0;
          popped = 1;
        end else m_beat++;
      end
      if (ila_trig) begin
        if (old == DEPTH) begin
          if (m_drop != 16'hFFFF) m_drop++;
          m_ovf = 1;
        end else mq.push_back(mkrec(m_ts, monitored_signal));
      end
      if (m_send) begin
        if (popped) m_send = (mq.size() != 0);
      end else m_send = (old != 0);
      m_ts = m_ts + 1;
    end
    cyc++;
    #1;
    chk("valid", u_if.out_valid, m_send);
    chk("last", u_if.out_last, m_send && m_beat == 6);
    if (m_send && mq.size() > 0) chk("data", u_if.out_data, mq[0][m_beat]);
    chk("level", fifo_level, mq.size());
    chk("drop", drop_count, m_drop);
    chk("ovf", overflow, m_ovf);
    p_valid = u_if.out_valid;
    p_data  = u_if.out_data;
    p_last  = u_if.out_last;
  end

  task automatic go_cycle(input int k);
    while (cyc < k) @(negedge in_clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic set_mon(input logic [31:0] base);
    for (int i = 0; i < 8; i++) monitored_signal[i*32 +: 32] = base + i;
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int k = 0;
    while (log_data.size() < n && k < budget) begin
      @(negedge in_clk);
      k++;
    end
    chk(nm, log_data.size() >= n, 1);
  endtask

  task automatic check_rec(input string nm, input int off, input logic [31:0] ts,
                           input logic [31:0] base);
    if (log_data.size() >= off + 7) begin
      chk({nm, "_ts"}, log_data[off], ts);
      for (int j = 1; j < 7; j++) chk({nm, "_word"}, log_data[off+j], base + mo[j]);
      for (int j = 0; j < 7; j++) chk({nm, "_lastflag"}, log_last[off+j], j == 6);
    end
  endtask

  initial begin
    int tcyc, rel, k;
    int rprob[4] = '{90, 50, 10, 70};
    in_reset = 0;
    u_if.out_ready = 1;
    set_mon(32'h10);
    go_cycle(2);
    chk("rst_valid", u_if.out_valid, 0);
    chk("rst_data", u_if.out_data, 0);
    chk("rst_last", u_if.out_last, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ovf", overflow, 0);
    in_reset = 1;

    // Single record
    go_cycle(10);
    ila_trig = 1;
    step(1);
    ila_trig = 0;
    wait_log(7, 40, "single_timeout");
    if (log_data.size() >= 7) begin
      check_rec("single", 0, 32'd8, 32'h10);
      chk("single_first_hs_cycle", log_cyc[0], 12);
      chk("single_last_hs_cycle", log_cyc[6], 18);
    end
    step(3);
    chk("single_level_end", fifo_level, 0);
    chk("single_hs_count", log_data.size(), 7);

    // Backpressure with ready pattern 1,0,0,1
    log_data.delete(); log_last.delete(); log_cyc.delete();
    set_mon(32'hA0);
    tcyc = cyc;
    for (int i = 0; i < 60; i++) begin
      ila_trig = (i == 0);
      u_if.out_ready = rpat[i % 4];
      @(negedge in_clk);
    end
    ila_trig = 0;
    u_if.out_ready = 1;
    step(3);
    chk("bp_hs_count", log_data.size(), 7);
    check_rec("bp", 0, 32'(tcyc - 2), 32'hA0);

    // Back-to-back triggers
    log_data.delete(); log_last.delete(); log_cyc.delete();
    set_mon(32'h50);
    tcyc = cyc;
    ila_trig = 1;
    step(2);
    ila_trig = 0;
    wait_log(14, 60, "b2b_timeout");
    if (log_data.size() >= 14) begin
      check_rec("b2b_r0", 0, 32'(tcyc - 2), 32'h50);
      check_rec("b2b_r1", 7, 32'(tcyc - 1), 32'h50);
      chk("b2b_no_gap", log_cyc[13] - log_cyc[0], 13);
      chk("b2b_ts_step", log_data[7], log_data[0] + 1);
    end

    // Overflow: 20 triggers with the consumer stalled
    step(2);
    u_if.out_ready = 0;
    set_mon(32'h300);
    ila_trig = 1;
    step(20);
    ila_trig = 0;
    step(1);
    chk("ovf_level", fifo_level, 16);
    chk("ovf_drop", drop_count, 4);
    chk("ovf_flag", overflow, 1);
    log_data.delete(); log_last.delete(); log_cyc.delete();
    u_if.out_ready = 1;
    k = 0;
    while (count_lasts() < 16 && k < 200) begin
      @(negedge in_clk);
      k++;
    end
    step(10);
    chk("ovf_drained_records", count_lasts(), 16);
    chk("ovf_drained_beats", log_data.size(), 112);
    chk("ovf_level_end", fifo_level, 0);
    chk("ovf_flag_sticky", overflow, 1);

    // Reset in the middle of a record
    log_data.delete(); log_last.delete(); log_cyc.delete();
    set_mon(32'hC0);
    ila_trig = 1;
    step(1);
    ila_trig = 0;
    wait_log(4, 40, "midrst_timeout");
    in_reset = 0;
    step(1);
    chk("midrst_valid", u_if.out_valid, 0);
    chk("midrst_data", u_if.out_data, 0);
    chk("midrst_last", u_if.out_last, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_drop", drop_count, 0);
    chk("midrst_ovf", overflow, 0);
    in_reset = 1;
    rel = cyc;
    log_data.delete(); log_last.delete(); log_cyc.delete();
    step(2);
    tcyc = cyc;
    ila_trig = 1;
    step(1);
    ila_trig = 0;
    wait_log(7, 40, "midrst_rec_timeout");
    step(3);
    chk("midrst_hs_count", log_data.size(), 7);
    check_rec("midrst", 0, 32'(tcyc - rel), 32'hC0);

    // Randomized traffic against the model
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 600; i++) begin
        ila_trig = ($urandom_range(99) < 35);
        u_if.out_ready = ($urandom_range(99) < rprob[s]);
        monitored_signal = {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
        in_reset = ($urandom_range(999) != 0);
        @(negedge in_clk);
      end
    end
    ila_trig = 0;
    in_reset = 1;
    u_if.out_ready = 1;
    step(150);
    chk("final_level", fifo_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
